// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers:
// control FSM encoding, per-stage bundle widths and the all-zero NOP bundle.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 158;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

  // All-zero bundle decodes as a NOP in every stage
  localparam logic [IDEX_W-1:0] PIPE_NOP = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot: async clear on reset, sync clear beats load enable so a
// killed or vacated slot always returns to the all-zero NOP bundle.
module pipe_entry_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, stall (hold) / flush (bubble) controls and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = IDEX_W,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [1:0]       state_q, state_d;
  logic             rdy_q;
  logic             take, give;
  logic             main_en, main_clr, skid_en, skid_clr;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic [CNT_W-1:0] cnt_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign give      = out_valid & out_ready & ~stall;
  assign take      = in_valid & in_ready;

  // rdy_q is low during reset, so in_ready only rises on the first edge after release
  generate
    if (SKID != 0) begin : g_rdy_reg
      assign in_ready = rdy_q;
    end else begin : g_rdy_comb
      assign in_ready = rdy_q & (~out_valid | give);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (take) state_d = ST_ONE;
      ST_ONE: begin
        if (take && !give && SKID != 0) state_d = ST_TWO;
        else if (give && !take)         state_d = ST_EMPTY;
      end
      ST_TWO:   if (give) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_TWO);
    end
  end

  // Main reloads from input when empty or draining-and-refilling, from skid when TWO drains
  assign main_en  = (take & ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & give)))
                  | ((state_q == ST_TWO) & give);
  assign main_d   = (state_q == ST_TWO) ? skid_q : in_data;
  assign main_clr = flush | (state_d == ST_EMPTY);
  assign skid_en  = (state_q == ST_ONE) & take & ~give;
  assign skid_clr = flush | ((state_q == ST_TWO) & give);

  pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .reset(reset), .clr(main_clr), .en(main_en), .d(main_d), .q(main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
        .clk(clk), .reset(reset), .clr(skid_clr), .en(skid_en), .d(in_data), .q(skid_q)
      );
    end else begin : g_noskid
      assign skid_q = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (~out_valid & out_ready & ~stall & ~flush & (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign out_data   = out_valid ? main_q : '0;
  assign occupancy  = state_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1, SKID=0 and a CNT_W=4 build
// share one stimulus bus; each task checks the instance it targets.
module tb_pipe_stage_reg;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, stall, flush, out_ready;
  logic [W-1:0] in_data;

  logic         r1_in_ready, r1_out_valid;
  logic [W-1:0] r1_out_data;
  logic [1:0]   r1_occ;
  logic [15:0]  r1_bub;

  logic         r0_in_ready, r0_out_valid;
  logic [W-1:0] r0_out_data;
  logic [1:0]   r0_occ;
  logic [15:0]  r0_bub;

  logic         rc_in_ready, rc_out_valid;
  logic [W-1:0] rc_out_data;
  logic [1:0]   rc_occ;
  logic [3:0]   rc_bub;

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1_in_ready), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(r1_out_valid), .out_ready(out_ready),
    .out_data(r1_out_data), .occupancy(r1_occ), .bubble_cnt(r1_bub));

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0_in_ready), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(r0_out_valid), .out_ready(out_ready),
    .out_data(r0_out_data), .occupancy(r0_occ), .bubble_cnt(r0_bub));

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(4)) uc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rc_in_ready), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(rc_out_valid), .out_ready(out_ready),
    .out_data(rc_out_data), .occupancy(rc_occ), .bubble_cnt(rc_bub));

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb[$];

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sb.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (r1_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", r1_in_ready); end
    checks++; if (r1_out_valid !== 1'b0 || r1_out_data !== '0) begin errors++; $display("FAIL rst_out: got v=%b d=%h want v=0 d=0", r1_out_valid, r1_out_data); end
    checks++; if (rc_bub !== 4'd0) begin errors++; $display("FAIL rst_bubble: got %0d want 0", rc_bub); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h000A;
    @(posedge clk); #1;
    in_data = 16'h000B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (r1_occ !== 2'd2 || r1_in_ready !== 1'b0) begin errors++; $display("FAIL fill_two: got occ=%0d rdy=%b want occ=2 rdy=0", r1_occ, r1_in_ready); end
    checks++; if (r1_out_data !== 16'h000A) begin errors++; $display("FAIL fill_head: got %h want 000a", r1_out_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if (r1_out_valid !== 1'b0 || r1_out_data !== '0 || r1_occ !== 2'd0) begin errors++; $display("FAIL async_clear: got v=%b d=%h occ=%0d want 0/0/0", r1_out_valid, r1_out_data, r1_occ); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (r1_in_ready !== 1'b1 || r1_occ !== 2'd0) begin errors++; $display("FAIL post_release: got rdy=%b occ=%0d want 1/0", r1_in_ready, r1_occ); end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      in_data  = W'(c + 1);
      @(negedge clk);
      if (c == 0) begin
        checks++; if (r1_out_valid !== 1'b0) begin errors++; $display("FAIL stream_lat0: got v=%b want 0", r1_out_valid); end
      end else if (c <= 4) begin
        checks++; if (r1_out_valid !== 1'b1 || r1_occ !== 2'd1) begin errors++; $display("FAIL stream_gap c=%0d: got v=%b occ=%0d want 1/1", c, r1_out_valid, r1_occ); end
      end else begin
        checks++; if (r1_out_valid !== 1'b0 || r1_out_data !== '0) begin errors++; $display("FAIL stream_idle: got v=%b d=%h want 0/0", r1_out_valid, r1_out_data); end
      end
      if (r1_out_valid && out_ready && !stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_underflow: got %h want nothing", r1_out_data); end
        else begin
          exp_d = sb.pop_front();
          if (r1_out_data !== exp_d) begin errors++; $display("FAIL stream_data: got %h want %h", r1_out_data, exp_d); end
        end
      end
      if (in_valid && r1_in_ready && !flush) sb.push_back(in_data);
      @(posedge clk); #1;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals [3];
    logic [W-1:0] exp_d;
    int idx = 0;
    int gives = 0;
    vals[0] = 16'd5; vals[1] = 16'd6; vals[2] = 16'd7;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      out_ready = (c >= 4);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? vals[idx] : '0;
      @(negedge clk);
      if (c == 2) begin
        checks++; if (r1_occ !== 2'd2 || r1_in_ready !== 1'b0 || r1_out_data !== 16'd5) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h want 2/0/0005", r1_occ, r1_in_ready, r1_out_data); end
      end
      if (c >= 4 && c <= 6) begin
        checks++; if (r1_out_valid !== 1'b1) begin errors++; $display("FAIL bp_gap c=%0d: got v=%b want 1", c, r1_out_valid); end
      end
      if (r1_out_valid && out_ready && !stall) begin
        gives++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_underflow: got %h want nothing", r1_out_data); end
        else begin
          exp_d = sb.pop_front();
          if (r1_out_data !== exp_d) begin errors++; $display("FAIL bp_data: got %h want %h", r1_out_data, exp_d); end
        end
      end
      if (in_valid && r1_in_ready && !flush) begin sb.push_back(in_data); idx++; end
      @(posedge clk); #1;
    end
    checks++; if (gives != 3 || sb.size() != 0) begin errors++; $display("FAIL bp_count: got gives=%0d left=%0d want 3/0", gives, sb.size()); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (r1_out_valid !== 1'b1 || r1_out_data !== 16'h0055) begin errors++; $display("FAIL stall_hold c=%0d: got v=%b d=%h want 1/0055", c, r1_out_valid, r1_out_data); end
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0066;
    @(negedge clk);
    checks++; if (r1_in_ready !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %b want 1", r1_in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (r1_out_valid !== 1'b0 || r1_out_data !== '0 || r1_occ !== 2'd0) begin errors++; $display("FAIL flush_kill c=%0d: got v=%b d=%h occ=%0d want 0/0/0", c, r1_out_valid, r1_out_data, r1_occ); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_skid0();
    logic [W-1:0] exp_d;
    logic [W-1:0] nxt = 16'h0100;
    logic         exp_rdy;
    int npush = 0;
    int npop = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      out_ready = (c < 12) ? (c % 2 == 0) : 1'b1;
      in_valid  = (c < 12);
      in_data   = nxt;
      @(negedge clk);
      exp_rdy = !r0_out_valid || (out_ready && !stall);
      checks++; if (r0_in_ready !== exp_rdy) begin errors++; $display("FAIL s0_rdy c=%0d: got %b want %b", c, r0_in_ready, exp_rdy); end
      if (r0_out_valid && out_ready && !stall) begin
        npop++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL s0_underflow: got %h want nothing", r0_out_data); end
        else begin
          exp_d = sb.pop_front();
          if (r0_out_data !== exp_d) begin errors++; $display("FAIL s0_data: got %h want %h", r0_out_data, exp_d); end
        end
      end
      if (in_valid && r0_in_ready && !flush) begin sb.push_back(in_data); npush++; nxt = nxt + 1'b1; end
      if (c == 1) begin
        out_ready = 1'b1;
        #1;
        checks++; if (r0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb: got %b want 1", r0_in_ready); end
        out_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++; if (npush != 6 || npop != 6 || sb.size() != 0) begin errors++; $display("FAIL s0_count: got push=%0d pop=%0d left=%0d want 6/6/0", npush, npop, sb.size()); end
  endtask

  task automatic test_counter();
    int exp_c = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      stall = (c == 3);
      flush = (c == 5);
      @(negedge clk);
      checks++; if (rc_bub !== exp_c[3:0]) begin errors++; $display("FAIL bubble c=%0d: got %0d want %0d", c, rc_bub, exp_c); end
      if (!stall && !flush && exp_c < 15) exp_c++;
      @(posedge clk); #1;
    end
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (rc_bub !== 4'hF) begin errors++; $display("FAIL bubble_sat: got %0d want 15", rc_bub); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall_flush();
    test_skid0();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
